// File: rtl/multicycle_ctrl.sv
// Multicycle processor control unit: FETCH/DECODE/EXEC/MEM/WB sequencing,
// immediate-extender mode, sticky illegal-opcode trap and retired counter.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [1:0]  ext_mode,
  output logic        alu_src_imm,
  output logic        reg_we,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_ADDI, C_LOGIC, C_LUI, C_LW, C_SW, C_BEQ, C_J
  } cls_t;

  state_t     cur, nxt;
  cls_t       cls, dec_cls;
  logic [1:0] dec_ext;
  logic       dec_legal;
  logic       retire;

  always_comb begin
    dec_cls   = C_R;
    dec_ext   = 2'b00;
    dec_legal = 1'b1;
    case (opcode)
      6'h00:         dec_cls = C_R;
      6'h08:         dec_cls = C_ADDI;
      6'h0C, 6'h0D: begin dec_cls = C_LOGIC; dec_ext = 2'b01; end
      6'h0F:        begin dec_cls = C_LUI;   dec_ext = 2'b10; end
      6'h23:         dec_cls = C_LW;
      6'h2B:         dec_cls = C_SW;
      6'h04:         dec_cls = C_BEQ;
      6'h02:         dec_cls = C_J;
      default:       dec_legal = 1'b0;
    endcase
  end

  // Strobes are forced low while rst is high so an aborted instruction
  // never produces a write or PC update during the reset cycle.
  always_comb begin
    nxt         = cur;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 2'b00;
    alu_src_imm = 1'b0;
    reg_we      = 1'b0;
    mem_to_reg  = 1'b0;
    if (!rst) begin
      case (cur)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
            nxt   = S_DECODE;
          end
        end
        S_DECODE: nxt = dec_legal ? S_EXEC : S_TRAP;
        S_EXEC: begin
          alu_src_imm = (cls == C_ADDI) || (cls == C_LOGIC) || (cls == C_LUI) ||
                        (cls == C_LW) || (cls == C_SW);
          case (cls)
            C_BEQ: begin
              pc_src = 2'b01;
              pc_we  = zero;
              nxt    = S_FETCH;
            end
            C_J: begin
              pc_src = 2'b10;
              pc_we  = 1'b1;
              nxt    = S_FETCH;
            end
            C_LW, C_SW: nxt = S_MEM;
            default:    nxt = S_WB;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = (cls == C_SW);
          if (mem_ack) nxt = (cls == C_LW) ? S_WB : S_FETCH;
        end
        S_WB: begin
          reg_we     = 1'b1;
          mem_to_reg = (cls == C_LW);
          nxt        = S_FETCH;
        end
        S_TRAP:  nxt = S_TRAP;
        default: nxt = S_FETCH;
      endcase
    end
  end

  assign retire = ((cur == S_EXEC) || (cur == S_MEM) || (cur == S_WB)) && (nxt == S_FETCH);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= S_FETCH;
      cls      <= C_R;
      ext_mode <= 2'b00;
      retired  <= 16'h0000;
      illegal  <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == S_DECODE) begin
        if (dec_legal) begin
          cls      <= dec_cls;
          ext_mode <= dec_ext;
        end else begin
          illegal  <= 1'b1;
        end
      end
      if (retire) retired <= retired + 16'd1;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each scenario drives a per-cycle
// stimulus table, pushes the expected outputs and compares them at negedge.
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ack;
  logic        mem_req, mem_we, ir_we, pc_we, alu_src_imm, reg_we, mem_to_reg, illegal;
  logic [1:0]  pc_src, ext_mode;
  logic [2:0]  state;
  logic [15:0] retired;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        r;
    logic        a;
    logic        z;
    logic [5:0]  op;
    logic [14:0] e;
  } row_t;

  row_t        stim[$];
  logic [14:0] sb[$];
  logic [14:0] e;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .ext_mode(ext_mode), .alu_src_imm(alu_src_imm),
    .reg_we(reg_we), .mem_to_reg(mem_to_reg), .illegal(illegal),
    .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] obs();
    return {state, mem_req, mem_we, ir_we, pc_we, pc_src, reg_we, mem_to_reg,
            alu_src_imm, ext_mode, illegal};
  endfunction

  function automatic logic [14:0] ex(input logic [2:0] st, input logic req, input logic we,
                                     input logic irw, input logic pcw, input logic [1:0] pcs,
                                     input logic rw, input logic m2r, input logic alu,
                                     input logic [1:0] em, input logic ill);
    return {st, req, we, irw, pcw, pcs, rw, m2r, alu, em, ill};
  endfunction

  task automatic add(input logic r, input logic a, input logic z, input logic [5:0] op,
                     input logic [14:0] ev);
    row_t t;
    t.r = r; t.a = a; t.z = z; t.op = op; t.e = ev;
    stim.push_back(t);
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ack = 1'b1; opcode = 6'h00; zero = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (obs() !== ex(0,0,0,0,0,2'd0,0,0,0,2'd0,0)) begin
      bad++; $display("FAIL reset_outputs got=%h want=%h", obs(), ex(0,0,0,0,0,2'd0,0,0,0,2'd0,0));
    end
    total++;
    if (retired !== 16'd0) begin bad++; $display("FAIL reset_retired got=%0d want=0", retired); end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    add(0,1,0,6'h00, ex(0,1,0,1,1,2'd0,0,0,0,2'd0,0));
    add(0,1,0,6'h00, ex(1,0,0,0,0,2'd0,0,0,0,2'd0,0));
    add(0,1,0,6'h00, ex(2,0,0,0,0,2'd0,0,0,0,2'd0,0));
    add(0,1,0,6'h00, ex(4,0,0,0,0,2'd0,1,0,0,2'd0,0));
    for (int i = 0; i < stim.size(); i++) begin
      rst = stim[i].r; mem_ack = stim[i].a; zero = stim[i].z; opcode = stim[i].op;
      sb.push_back(stim[i].e);
      @(negedge clk); e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL rtype cyc=%0d got=%h want=%h", i, obs(), e); end
      @(posedge clk); #1;
    end
    stim.delete();
    total++;
    if (retired !== 16'd1) begin bad++; $display("FAIL rtype_retired got=%0d want=1", retired); end
  endtask

  task automatic test_lw_wait();
    add(0,1,0,6'h23, ex(0,1,0,1,1,2'd0,0,0,0,2'd0,0));
    add(0,1,0,6'h23, ex(1,0,0,0,0,2'd0,0,0,0,2'd0,0));
    add(0,1,0,6'h23, ex(2,0,0,0,0,2'd0,0,0,1,2'd0,0));
    add(0,0,0,6'h23, ex(3,1,0,0,0,2'd0,0,0,0,2'd0,0));
    add(0,0,0,6'h23, ex(3,1,0,0,0,2'd0,0,0,0,2'd0,0));
    add(0,1,0,6'h23, ex(3,1,0,0,0,2'd0,0,0,0,2'd0,0));
    add(0,1,0,6'h23, ex(4,0,0,0,0,2'd0,1,1,0,2'd0,0));
    for (int i = 0; i < stim.size(); i++) begin
      rst = stim[i].r; mem_ack = stim[i].a; zero = stim[i].z; opcode = stim[i].op;
      sb.push_back(stim[i].e);
      @(negedge clk); e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL lw cyc=%0d got=%h want=%h", i, obs(), e); end
      @(posedge clk); #1;
    end
    stim.delete();
    total++;
    if (retired !== 16'd2) begin bad++; $display("FAIL lw_retired got=%0d want=2", retired); end
  endtask

  task automatic test_ext_mode();
    add(0,1,0,6'h0D, ex(0,1,0,1,1,2'd0,0,0,0,2'd0,0));
    add(0,1,0,6'h0D, ex(1,0,0,0,0,2'd0,0,0,0,2'd0,0));
    add(0,1,0,6'h0D, ex(2,0,0,0,0,2'd0,0,0,1,2'd1,0));
    add(0,1,0,6'h0D, ex(4,0,0,0,0,2'd0,1,0,0,2'd1,0));
    add(0,1,0,6'h0F, ex(0,1,0,1,1,2'd0,0,0,0,2'd1,0));
    add(0,1,0,6'h0F, ex(1,0,0,0,0,2'd0,0,0,0,2'd1,0));
    add(0,1,0,6'h0F, ex(2,0,0,0,0,2'd0,0,0,1,2'd2,0));
    add(0,1,0,6'h0F, ex(4,0,0,0,0,2'd0,1,0,0,2'd2,0));
    for (int i = 0; i < stim.size(); i++) begin
      rst = stim[i].r; mem_ack = stim[i].a; zero = stim[i].z; opcode = stim[i].op;
      sb.push_back(stim[i].e);
      @(negedge clk); e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL ori_lui cyc=%0d got=%h want=%h", i, obs(), e); end
      @(posedge clk); #1;
    end
    stim.delete();
    total++;
    if (retired !== 16'd4) begin bad++; $display("FAIL ori_lui_retired got=%0d want=4", retired); end
  endtask

  task automatic test_branch_jump();
    add(0,1,1,6'h04, ex(0,1,0,1,1,2'd0,0,0,0,2'd2,0));
    add(0,1,1,6'h04, ex(1,0,0,0,0,2'd0,0,0,0,2'd2,0));
    add(0,1,0,6'h04, ex(2,0,0,0,0,2'd1,0,0,0,2'd0,0));
    add(0,1,1,6'h04, ex(0,1,0,1,1,2'd0,0,0,0,2'd0,0));
    add(0,1,1,6'h04, ex(1,0,0,0,0,2'd0,0,0,0,2'd0,0));
    add(0,1,1,6'h04, ex(2,0,0,0,1,2'd1,0,0,0,2'd0,0));
    add(0,1,0,6'h02, ex(0,1,0,1,1,2'd0,0,0,0,2'd0,0));
    add(0,1,0,6'h02, ex(1,0,0,0,0,2'd0,0,0,0,2'd0,0));
    add(0,1,0,6'h02, ex(2,0,0,0,1,2'd2,0,0,0,2'd0,0));
    for (int i = 0; i < stim.size(); i++) begin
      rst = stim[i].r; mem_ack = stim[i].a; zero = stim[i].z; opcode = stim[i].op;
      sb.push_back(stim[i].e);
      @(negedge clk); e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL beq_j cyc=%0d got=%h want=%h", i, obs(), e); end
      @(posedge clk); #1;
    end
    stim.delete();
    total++;
    if (retired !== 16'd7) begin bad++; $display("FAIL beq_j_retired got=%0d want=7", retired); end
  endtask

  task automatic test_sw_abort();
    add(1,1,0,6'h2B, ex(0,0,0,0,0,2'd0,0,0,0,2'd0,0));
    add(0,1,0,6'h2B, ex(0,1,0,1,1,2'd0,0,0,0,2'd0,0));
    add(0,1,0,6'h2B, ex(1,0,0,0,0,2'd0,0,0,0,2'd0,0));
    add(0,1,0,6'h2B, ex(2,0,0,0,0,2'd0,0,0,1,2'd0,0));
    add(0,0,0,6'h2B, ex(3,1,1,0,0,2'd0,0,0,0,2'd0,0));
    add(0,0,0,6'h2B, ex(3,1,1,0,0,2'd0,0,0,0,2'd0,0));
    add(1,0,0,6'h2B, ex(3,0,0,0,0,2'd0,0,0,0,2'd0,0));
    add(0,0,0,6'h2B, ex(0,1,0,0,0,2'd0,0,0,0,2'd0,0));
    add(0,0,0,6'h2B, ex(0,1,0,0,0,2'd0,0,0,0,2'd0,0));
    for (int i = 0; i < stim.size(); i++) begin
      rst = stim[i].r; mem_ack = stim[i].a; zero = stim[i].z; opcode = stim[i].op;
      sb.push_back(stim[i].e);
      @(negedge clk); e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL sw_abort cyc=%0d got=%h want=%h", i, obs(), e); end
      @(posedge clk); #1;
    end
    stim.delete();
    total++;
    if (retired !== 16'd0) begin bad++; $display("FAIL sw_abort_retired got=%0d want=0", retired); end
  endtask

  task automatic test_trap();
    add(0,1,0,6'h3F, ex(0,1,0,1,1,2'd0,0,0,0,2'd0,0));
    add(0,1,0,6'h3F, ex(1,0,0,0,0,2'd0,0,0,0,2'd0,0));
    for (int k = 0; k < 20; k++) add(0,1,k[0],6'h00, ex(7,0,0,0,0,2'd0,0,0,0,2'd0,1));
    add(1,1,0,6'h00, ex(7,0,0,0,0,2'd0,0,0,0,2'd0,1));
    add(0,0,0,6'h00, ex(0,1,0,0,0,2'd0,0,0,0,2'd0,0));
    for (int i = 0; i < stim.size(); i++) begin
      rst = stim[i].r; mem_ack = stim[i].a; zero = stim[i].z; opcode = stim[i].op;
      sb.push_back(stim[i].e);
      @(negedge clk); e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL trap cyc=%0d got=%h want=%h", i, obs(), e); end
      @(posedge clk); #1;
    end
    stim.delete();
    total++;
    if (retired !== 16'd0) begin bad++; $display("FAIL trap_retired got=%0d want=0", retired); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_ext_mode();
    test_branch_jump();
    test_sw_abort();
    test_trap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
